led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised LED pattern generator; successor to the fixed 8-bit ~1 s blink counter.
//  A programmable prescaler and speed divider advance a WIDTH-bit pattern register.
//  Four pattern modes, with pause/single-step and tick/wrap status pulses.
//  Sits behind the top-level wrapper; leds drives uo_out, tick/wrap go to debug pins.
// PARAMETERS
//  WIDTH        8         pattern/LED width; must be >= 2
//  PRESCALE_W   25        prescaler counter width
//  PRESCALE_MAX 24999999  prescaler terminal value; period = PRESCALE_MAX+1 clk cycles
// PORTS
//  clk     in   1      system clock; all state on posedge
//  rst_n   in   1      async active-low reset
//  ena     in   1      global enable; 0 freezes all state (prescaler, divider, pattern)
//  mode    in   2      0=bin up, 1=bin down, 2=bounce (one-hot), 3=gray up
//  speed   in   2      advance every 2^speed prescaler terminals (1,2,4,8)
//  pause   in   1      1 = prescaler/divider held; pattern advances only via step
//  step    in   1      while pause=1: each cycle high = one advance
//  leds    out  WIDTH  current pattern
//  tick    out  1      1-cycle pulse coincident with every leds update by advance
//  wrap    out  1      1-cycle pulse when the pattern completes a full cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): pre_cnt=0, sub_cnt=0, cnt=0, dir=left, mode_q=0, leds=0, tick=0, wrap=0.
//  Every clk with ena=0: all registers hold; tick=wrap=0.
//  Prescaler (ena=1, pause=0):
//   - pre_cnt increments; at PRESCALE_MAX it wraps to 0 and pulses pre_tick.
//   - On pre_tick, sub_cnt(3b) increments.
//   - If sub_cnt == (1<<speed)-1: sub_cnt->0 and advance=1.
//   - speed changed mid-count: compare uses new value; if sub_cnt already exceeds it,
//     sub_cnt->0 with advance on the next pre_tick.
//  Pause (ena=1, pause=1): pre_cnt and sub_cnt hold; advance = step.
//   Leaving pause resumes from held counts.
//  Mode change: mode_q registers mode each cycle.
//   - On mode != mode_q: pattern reloads next cycle (up/gray: cnt=0; down: cnt=all-ones;
//     bounce: cnt=1, dir=left).
//   - pre_cnt and sub_cnt clear; no tick/wrap.
//   - Reload has priority over a coincident advance.
//  Advance (registered; leds, tick and wrap update together, 1 cycle after the advance condition):
//   - mode0: cnt+1 mod 2^WIDTH; wrap when all-ones->0.
//   - mode1: cnt-1 mod 2^WIDTH; wrap when 0->all-ones.
//   - mode2: one-hot shift in dir.
//     * At bit WIDTH-1, dir flips to right and the next shift goes down.
//     * At bit0, dir flips to left.
//     * wrap when leds becomes bit0 (period 2*WIDTH-2 advances).
//     * A non-one-hot cnt (e.g. 0 after reset) becomes 1 on advance.
//   - mode3: binary cnt+1 as mode0; leds = cnt ^ (cnt>>1); wrap as mode0.
//  leds = cnt in modes 0-2. No combinational path from any input to outputs.
// TESTING (PRESCALE_MAX=3, WIDTH=8 unless noted)
//  1. Reset mid-count, then mode=0, speed=0, ena=1, pause=0 -> leds 0,1,2,... every 4 clk;
//     tick each update.
//     Then rst_n=0 mid-count -> leds=0 immediately.
//  2. mode=0 run 1024 clk -> leds wraps FF->00 with wrap=1 that cycle only.
//     speed=3 -> update every 32 clk.
//  3. mode=1 from reload (FF) -> FE,FD,...; wrap on 00->FF.
//     mode=3 -> leds 00,01,03,02,06,07,05,04.
//  4. mode=2, WIDTH=4 -> 1,2,4,8,4,2,1; wrap on the return to 1 (after 6 advances).
//  5. pause=1 with 3 one-cycle step pulses -> exactly 3 advances.
//     ena=0 for 100 clk -> leds unchanged.
//     Mode change concurrent with advance -> reload value, no tick.

Source files
------------

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle for led_pattern_gen: mode/speed/pause controls in,
// LED pattern and tick/wrap status pulses out.
interface led_pattern_gen_if #(
    parameter int WIDTH = 8
) ();
    logic             ena;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic             pause;
    logic             step;
    logic [WIDTH-1:0] leds;
    logic             tick;
    logic             wrap;

    modport master (
        output ena, mode, speed, pause, step,
        input  leds, tick, wrap
    );

    modport slave (
        input  ena, mode, speed, pause, step,
        output leds, tick, wrap
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaler plus 2^speed divider advance a WIDTH-bit
// pattern in binary up/down, one-hot bounce or gray-up mode, with pause/step.
module led_pattern_gen #(
    parameter int WIDTH        = 8,
    parameter int PRESCALE_W   = 25,
    parameter int PRESCALE_MAX = 24999999
) (
    input  logic               clk,
    input  logic               rst_n,
    led_pattern_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_GRAY   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    logic [PRESCALE_W-1:0] r_pre_cnt, w_pre_cnt;
    logic [2:0]            r_sub_cnt, w_sub_cnt;
    logic [WIDTH-1:0]      r_cnt,     w_cnt;
    dir_e                  r_dir,     w_dir;
    mode_e                 r_mode_q,  w_mode_q;
    logic                  r_tick,    w_tick;
    logic                  r_wrap,    w_wrap;

    mode_e                 w_mode;
    logic [2:0]            w_limit;
    logic                  w_advance;
    logic                  w_onehot;
    dir_e                  w_eff_dir;
    logic [WIDTH-1:0]      w_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
            r_sub_cnt <= '0;
            r_cnt     <= '0;
            r_dir     <= DIR_LEFT;
            r_mode_q  <= MODE_UP;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_pre_cnt <= w_pre_cnt;
            r_sub_cnt <= w_sub_cnt;
            r_cnt     <= w_cnt;
            r_dir     <= w_dir;
            r_mode_q  <= w_mode_q;
            r_tick    <= w_tick;
            r_wrap    <= w_wrap;
        end
    end

    always_comb begin
        w_pre_cnt = r_pre_cnt;
        w_sub_cnt = r_sub_cnt;
        w_cnt     = r_cnt;
        w_dir     = r_dir;
        w_mode_q  = r_mode_q;
        w_tick    = 1'b0;
        w_wrap    = 1'b0;
        w_advance = 1'b0;
        w_eff_dir = r_dir;
        w_shift   = r_cnt;
        w_mode    = mode_e'(bus.mode);
        w_limit   = 3'((4'd1 << bus.speed) - 4'd1);
        w_onehot  = (r_cnt != '0) && ((r_cnt & (r_cnt - WIDTH'(1))) == '0);

        if (bus.ena) begin
            if (w_mode != r_mode_q) begin
                // Reload wins over any advance that lands in the same cycle.
                w_mode_q  = w_mode;
                w_pre_cnt = '0;
                w_sub_cnt = '0;
                case (w_mode)
                    MODE_DOWN:   w_cnt = '1;
                    MODE_BOUNCE: begin
                        w_cnt = WIDTH'(1);
                        w_dir = DIR_LEFT;
                    end
                    default:     w_cnt = '0;
                endcase
            end else begin
                if (bus.pause) begin
                    w_advance = bus.step;
                end else if (r_pre_cnt == PRESCALE_W'(PRESCALE_MAX)) begin
                    w_pre_cnt = '0;
                    // >= so that lowering speed mid-count still advances next terminal.
                    if (r_sub_cnt >= w_limit) begin
                        w_sub_cnt = '0;
                        w_advance = 1'b1;
                    end else begin
                        w_sub_cnt = r_sub_cnt + 3'd1;
                    end
                end else begin
                    w_pre_cnt = r_pre_cnt + PRESCALE_W'(1);
                end

                if (w_advance) begin
                    w_tick = 1'b1;
                    case (r_mode_q)
                        MODE_DOWN: begin
                            w_cnt  = r_cnt - WIDTH'(1);
                            w_wrap = (r_cnt == '0);
                        end
                        MODE_BOUNCE: begin
                            if (!w_onehot) begin
                                w_cnt  = WIDTH'(1);
                                w_dir  = DIR_LEFT;
                                w_wrap = 1'b1;
                            end else begin
                                if (r_cnt[WIDTH-1])
                                    w_eff_dir = DIR_RIGHT;
                                else if (r_cnt[0])
                                    w_eff_dir = DIR_LEFT;
                                w_shift = (w_eff_dir == DIR_LEFT) ? (r_cnt << 1) : (r_cnt >> 1);
                                w_cnt   = w_shift;
                                w_dir   = w_eff_dir;
                                w_wrap  = (w_shift == WIDTH'(1));
                            end
                        end
                        default: begin
                            w_cnt  = r_cnt + WIDTH'(1);
                            w_wrap = (r_cnt == '1);
                        end
                    endcase
                end
            end
        end
    end

    assign bus.leds = (r_mode_q == MODE_GRAY) ? (r_cnt ^ (r_cnt >> 1)) : r_cnt;
    assign bus.tick = r_tick;
    assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: expected leds/wrap are queued as
// stimulus is applied and popped on every tick from the DUT.
module tb_led_pattern_gen;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    led_pattern_gen_if #(.WIDTH(8)) bus8 ();
    led_pattern_gen_if #(.WIDTH(4)) bus4 ();

    led_pattern_gen #(.WIDTH(8), .PRESCALE_W(2), .PRESCALE_MAX(3)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    led_pattern_gen #(.WIDTH(4), .PRESCALE_W(2), .PRESCALE_MAX(3)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    typedef struct packed {
        logic [7:0] leds;
        logic       wrap;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ticks8   = 0;
    int   ticks4   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push8(input logic [7:0] v, input logic w);
        exp_t e;
        e.leds = v;
        e.wrap = w;
        q8.push_back(e);
    endtask

    task automatic push4(input logic [7:0] v, input logic w);
        exp_t e;
        e.leds = v;
        e.wrap = w;
        q4.push_back(e);
    endtask

    task automatic wait_ticks(input int n, input int budget, output int cyc);
        int seen;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus8.tick) seen++;
        end
        check_eq("tick_count", 32'(seen), 32'(n));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus8.tick) begin
                exp_t e;
                ticks8++;
                if (q8.size() == 0) begin
                    check_eq("tick8_queue", 32'(q8.size()), 32'd1);
                end else begin
                    e = q8.pop_front();
                    check_eq("leds8", 32'(bus8.leds), 32'(e.leds));
                    check_eq("wrap8", 32'(bus8.wrap), 32'(e.wrap));
                end
            end else if (bus8.wrap) begin
                check_eq("wrap8_no_tick", 32'(bus8.wrap), 32'd0);
            end
            if (bus4.tick) begin
                exp_t e;
                ticks4++;
                if (q4.size() == 0) begin
                    check_eq("tick4_queue", 32'(q4.size()), 32'd1);
                end else begin
                    e = q4.pop_front();
                    check_eq("leds4", 32'(bus4.leds), 32'(e.leds));
                    check_eq("wrap4", 32'(bus4.wrap), 32'(e.wrap));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         t0;
        logic [7:0] v;
        logic [7:0] gray_seq [7];
        logic [7:0] bounce4_seq [6];

        gray_seq    = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
        bounce4_seq = '{8'h2, 8'h4, 8'h8, 8'h4, 8'h2, 8'h1};

        rst_n = 1'b0;
        bus8.ena = 1'b0; bus8.mode = 2'd0; bus8.speed = 2'd0; bus8.pause = 1'b0; bus8.step = 1'b0;
        bus4.ena = 1'b0; bus4.mode = 2'd0; bus4.speed = 2'd0; bus4.pause = 1'b0; bus4.step = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_leds", 32'(bus8.leds), 32'd0);
        check_eq("reset_tick", 32'(bus8.tick), 32'd0);
        check_eq("reset_wrap", 32'(bus8.wrap), 32'd0);

        // Binary up at speed 0: one advance every 4 clocks
        bus8.ena = 1'b1;
        rst_n    = 1'b1;
        for (int i = 1; i <= 5; i++) push8(8'(i), 1'b0);
        wait_ticks(1, 10, cyc);
        wait_ticks(4, 40, cyc);
        check_eq("period_speed0", 32'(cyc), 32'd16);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_leds", 32'(bus8.leds), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full wrap FF->00, then speed 3
        for (int i = 1; i <= 255; i++) push8(8'(i), 1'b0);
        push8(8'h00, 1'b1);
        push8(8'h01, 1'b0);
        wait_ticks(257, 1100, cyc);
        bus8.speed = 2'd3;
        push8(8'h02, 1'b0);
        wait_ticks(1, 40, cyc);
        push8(8'h03, 1'b0);
        push8(8'h04, 1'b0);
        wait_ticks(2, 80, cyc);
        check_eq("period_speed3", 32'(cyc), 32'd64);

        // Binary down from reload
        bus8.mode  = 2'd1;
        bus8.speed = 2'd0;
        @(negedge clk);
        check_eq("reload_down", 32'(bus8.leds), 32'hFF);
        check_eq("reload_no_tick", 32'(bus8.tick), 32'd0);
        for (int i = 254; i >= 0; i--) push8(8'(i), 1'b0);
        push8(8'hFF, 1'b1);
        push8(8'hFE, 1'b0);
        wait_ticks(257, 1100, cyc);

        // Gray up
        bus8.mode = 2'd3;
        @(negedge clk);
        check_eq("reload_gray", 32'(bus8.leds), 32'd0);
        for (int i = 0; i < 7; i++) push8(gray_seq[i], 1'b0);
        wait_ticks(7, 40, cyc);

        // Bounce on both widths, running in lockstep
        bus8.mode = 2'd2;
        bus4.ena  = 1'b1;
        bus4.mode = 2'd2;
        @(negedge clk);
        check_eq("reload_bounce8", 32'(bus8.leds), 32'd1);
        check_eq("reload_bounce4", 32'(bus4.leds), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            v = 8'd1 << i;
            push8(v, 1'b0);
        end
        for (int i = 6; i >= 1; i--) begin
            v = 8'd1 << i;
            push8(v, 1'b0);
        end
        push8(8'h01, 1'b1);
        push8(8'h02, 1'b0);
        for (int i = 0; i < 15; i++) push4(bounce4_seq[i % 6], bounce4_seq[i % 6] == 8'h1);
        wait_ticks(15, 80, cyc);
        bus4.ena = 1'b0;
        @(negedge clk);
        check_eq("ticks4_total", 32'(ticks4), 32'd15);

        // Pause with single steps
        bus8.mode  = 2'd0;
        bus8.pause = 1'b1;
        @(negedge clk);
        check_eq("reload_up_paused", 32'(bus8.leds), 32'd0);
        t0 = ticks8;
        for (int k = 1; k <= 3; k++) begin
            push8(8'(k), 1'b0);
            bus8.step = 1'b1;
            @(negedge clk);
            bus8.step = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        check_eq("step_advances", 32'(ticks8 - t0), 32'd3);
        check_eq("step_leds", 32'(bus8.leds), 32'd3);

        // Global disable freezes everything
        bus8.pause = 1'b0;
        bus8.ena   = 1'b0;
        t0 = ticks8;
        repeat (100) @(negedge clk);
        check_eq("ena0_leds", 32'(bus8.leds), 32'd3);
        check_eq("ena0_ticks", 32'(ticks8 - t0), 32'd0);

        // Mode change coincident with a step advance
        bus8.ena   = 1'b1;
        bus8.pause = 1'b1;
        bus8.step  = 1'b1;
        bus8.mode  = 2'd1;
        @(negedge clk);
        check_eq("coincide_leds", 32'(bus8.leds), 32'hFF);
        check_eq("coincide_tick", 32'(bus8.tick), 32'd0);
        bus8.step = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("q8_empty", 32'(q8.size()), 32'd0);
        check_eq("q4_empty", 32'(q4.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
